// File: rtl/drum_voice_player_pkg.sv
// rtl/drum_voice_player_pkg.sv - shared types and constants for the drum voice player
package drum_voice_player_pkg;

    // Width of the attenuation (arithmetic right-shift) control
    localparam int ATTEN_W = 3;

    // Playback FSM: IDLE waits for a trigger, PLAY streams one hit
    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/drum_voice_player_atten.sv
// rtl/drum_voice_player_atten.sv - combinational sign-preserving sample attenuator
// Ports:
//   sample_i  DATA_W   signed two's complement input sample
//   shift_i   ATTEN_W  arithmetic right-shift amount
//   sample_o  DATA_W   attenuated signed sample
module sample_atten
    import drum_voice_player_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]  sample_i,
    input  logic [ATTEN_W-1:0] shift_i,
    output logic [DATA_W-1:0]  sample_o
);

    logic signed [DATA_W-1:0] sample_s;

    assign sample_s = sample_i;
    assign sample_o = sample_s >>> shift_i;

endmodule

// File: rtl/drum_voice_player.sv
// rtl/drum_voice_player.sv - one-shot drum sample player driving a synchronous sample ROM
// Ports:
//   clk, nrst     clock, asynchronous active-low reset
//   trig          start / retrigger pulse
//   sample_tick   audio-rate strobe requesting the next sample
//   atten         arithmetic right-shift applied to each sample
//   rom_addr      ROM read address (ptr while playing, 0 when idle)
//   rom_data      ROM read data, one cycle after rom_addr
//   audio_out     attenuated signed sample, audio_valid pulses on update
//   busy          high while a hit plays, done pulses on natural end
module drum_voice_player
    import drum_voice_player_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int SAMPLE_LEN = 4096
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               trig,
    input  logic               sample_tick,
    input  logic [ATTEN_W-1:0] atten,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  audio_out,
    output logic               audio_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(SAMPLE_LEN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                fetch_q, fetch_d;
    // Set during the cycle the final sample is presented; ends the hit next cycle
    logic                last_q, last_d;
    logic [DATA_W-1:0]   audio_q, audio_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   atten_sample;

    sample_atten #(
        .DATA_W (DATA_W)
    ) u_atten (
        .sample_i (rom_data),
        .shift_i  (atten),
        .sample_o (atten_sample)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fetch_q <= 1'b0;
            last_q  <= 1'b0;
            audio_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fetch_q <= fetch_d;
            last_q  <= last_d;
            audio_q <= audio_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fetch_d = 1'b0;
        last_d  = 1'b0;
        audio_d = audio_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ptr_d   = '0;
                audio_d = '0;
                // A tick coinciding with the trigger is deliberately dropped
                if (trig) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (trig) begin
                    // Retrigger outranks everything: pending fetch and natural end are discarded
                    ptr_d = '0;
                end else if (last_q) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    audio_d = '0;
                    done_d  = 1'b1;
                end else if (fetch_q) begin
                    audio_d = atten_sample;
                    valid_d = 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        last_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end else if (sample_tick) begin
                    fetch_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_addr    = (state_q == PLAY) ? ptr_q : '0;
    assign audio_out   = audio_q;
    assign audio_valid = valid_q;
    assign busy        = (state_q == PLAY);
    assign done        = done_q;

endmodule
